// File: rtl/vinstr_queue_if.sv
// Handshake and head-of-queue bus between the scalar core, the vector queue and the vector controller.
// The slave modport is the queue; the master modport is the core/controller side.
interface vinstr_queue_if #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8
);
  localparam int CW = $clog2(DEPTH + 1);

  logic                  flush_i;
  logic                  push_i;
  logic [DATA_WIDTH-1:0] instr_i;
  logic [DATA_WIDTH-1:0] rs1_i;
  logic [DATA_WIDTH-1:0] rs2_i;
  logic                  push_ready_o;
  logic                  pop_i;
  logic [DATA_WIDTH-1:0] instr_o;
  logic [DATA_WIDTH-1:0] rs1_o;
  logic [DATA_WIDTH-1:0] rs2_o;
  logic                  empty_o;
  logic                  full_o;
  logic                  almost_full_o;
  logic [CW-1:0]         count_o;
  logic                  err_clr_i;
  logic                  overflow_o;
  logic                  underflow_o;

  modport master (
    output flush_i, push_i, instr_i, rs1_i, rs2_i, pop_i, err_clr_i,
    input  push_ready_o, instr_o, rs1_o, rs2_o, empty_o, full_o,
           almost_full_o, count_o, overflow_o, underflow_o
  );

  modport slave (
    input  flush_i, push_i, instr_i, rs1_i, rs2_i, pop_i, err_clr_i,
    output push_ready_o, instr_o, rs1_o, rs2_o, empty_o, full_o,
           almost_full_o, count_o, overflow_o, underflow_o
  );
endinterface

// File: rtl/vinstr_queue.sv
// First-word-fall-through queue of vector instructions with their rs1/rs2 operands,
// with flush, back-pressure and sticky overflow/underflow flags.
module vinstr_queue #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8,
  parameter int AF_MARGIN  = 2
) (
  input  logic           clk_i,
  input  logic           rst_i,
  vinstr_queue_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] AF_TH    = CW'(DEPTH - AF_MARGIN);

  logic [DATA_WIDTH-1:0] instr_mem [DEPTH];
  logic [DATA_WIDTH-1:0] rs1_mem   [DEPTH];
  logic [DATA_WIDTH-1:0] rs2_mem   [DEPTH];

  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          udf_q, udf_d;

  logic empty, full, do_push, do_pop, ovf_evt, udf_evt;

  assign empty = (count_q == '0);
  assign full  = (count_q == FULL_CNT);

  // Flush swallows everything offered in its cycle, including error events.
  assign do_push = bus.push_i && !full  && !bus.flush_i;
  assign do_pop  = bus.pop_i  && !empty && !bus.flush_i;
  assign ovf_evt = bus.push_i && full   && !bus.flush_i;
  assign udf_evt = bus.pop_i  && empty  && !bus.flush_i;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (bus.flush_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (do_push) wptr_d = wptr_q + AW'(1);
      if (do_pop)  rptr_d = rptr_q + AW'(1);
      if (do_push && !do_pop)      count_d = count_q + CW'(1);
      else if (!do_push && do_pop) count_d = count_q - CW'(1);
    end
    ovf_d = (ovf_q && !bus.err_clr_i) || ovf_evt;
    udf_d = (udf_q && !bus.err_clr_i) || udf_evt;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  // Storage carries no reset; stale entries are masked by the empty check below.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      instr_mem[wptr_q] <= bus.instr_i;
      rs1_mem[wptr_q]   <= bus.rs1_i;
      rs2_mem[wptr_q]   <= bus.rs2_i;
    end
  end

  assign bus.instr_o       = empty ? '0 : instr_mem[rptr_q];
  assign bus.rs1_o         = empty ? '0 : rs1_mem[rptr_q];
  assign bus.rs2_o         = empty ? '0 : rs2_mem[rptr_q];
  assign bus.empty_o       = empty;
  assign bus.full_o        = full;
  assign bus.push_ready_o  = !full;
  assign bus.almost_full_o = (count_q >= AF_TH);
  assign bus.count_o       = count_q;
  assign bus.overflow_o    = ovf_q;
  assign bus.underflow_o   = udf_q;
endmodule

// File: tb/tb_vinstr_queue.sv
// Randomized self-checking bench for vinstr_queue against a queue-based reference model.
module tb_vinstr_queue;
  localparam int DW    = 32;
  localparam int DEPTH = 8;
  localparam int AFM   = 2;
  localparam int VW    = 4 + 6 + 3*DW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  vinstr_queue_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

  vinstr_queue #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_MARGIN(AFM)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  logic [3*DW-1:0] mq [$];
  bit m_ovf = 1'b0;
  bit m_udf = 1'b0;

  function automatic logic [VW-1:0] expv();
    int sz = mq.size();
    logic [3*DW-1:0] head = (sz != 0) ? mq[0] : '0;
    return {4'(sz), sz == 0, sz == DEPTH, sz != DEPTH, sz >= DEPTH - AFM,
            m_ovf, m_udf, head};
  endfunction

  function automatic logic [VW-1:0] obsv();
    return {bus.count_o, bus.empty_o, bus.full_o, bus.push_ready_o,
            bus.almost_full_o, bus.overflow_o, bus.underflow_o,
            bus.instr_o, bus.rs1_o, bus.rs2_o};
  endfunction

  task automatic idle_inputs();
    bus.flush_i = 0; bus.push_i = 0; bus.pop_i = 0; bus.err_clr_i = 0;
    bus.instr_i = '0; bus.rs1_i = '0; bus.rs2_i = '0;
  endtask

  // One clock cycle of stimulus; the model advances by the queue's rules.
  task automatic drive(input bit fl, input bit pu, input bit po, input bit cl,
                       input logic [DW-1:0] ins, input logic [DW-1:0] r1,
                       input logic [DW-1:0] r2);
    int  sz;
    bit  pa, pp;
    bus.flush_i = fl; bus.push_i = pu; bus.pop_i = po; bus.err_clr_i = cl;
    bus.instr_i = ins; bus.rs1_i = r1; bus.rs2_i = r2;
    @(posedge clk);
    sz = mq.size();
    pa = pu && (sz != DEPTH);
    pp = po && (sz != 0);
    if (fl) mq.delete();
    else begin
      if (pp) void'(mq.pop_front());
      if (pa) mq.push_back({ins, r1, r2});
    end
    m_ovf = (m_ovf && !cl) || (!fl && pu && sz == DEPTH);
    m_udf = (m_udf && !cl) || (!fl && po && sz == 0);
    #1;
    idle_inputs();
  endtask

  task automatic clean();
    drive(1, 0, 0, 1, '0, '0, '0);
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    mq.delete(); m_ovf = 0; m_udf = 0;
    vectors++;
    if (obsv() !== expv()) begin
      miscompares++;
      $display("FAIL reset: got %h want %h", obsv(), expv());
    end
  endtask

  task automatic test_single();
    drive(0, 1, 0, 0, 32'h0000_1057, 32'h10, 32'h4);
    vectors++;
    if (obsv() !== expv() || bus.instr_o !== 32'h0000_1057 || bus.count_o !== 4'd1) begin
      miscompares++;
      $display("FAIL single_push: got %h want %h", obsv(), expv());
    end
    drive(0, 0, 1, 0, '0, '0, '0);
    vectors++;
    if (obsv() !== expv() || bus.empty_o !== 1'b1 || bus.instr_o !== '0) begin
      miscompares++;
      $display("FAIL single_pop: got %h want %h", obsv(), expv());
    end
  endtask

  task automatic test_fill_overflow();
    clean();
    for (int i = 0; i < DEPTH + 1; i++) begin
      drive(0, 1, 0, 0, {16'(i + 1), 16'($urandom)}, $urandom, $urandom);
      vectors++;
      if (obsv() !== expv()) begin
        miscompares++;
        $display("FAIL fill_%0d: got %h want %h", i, obsv(), expv());
      end
    end
    vectors++;
    if (bus.overflow_o !== 1'b1 || bus.count_o !== 4'(DEPTH)) begin
      miscompares++;
      $display("FAIL overflow_on_full: got ovf=%b cnt=%0d want ovf=1 cnt=%0d",
               bus.overflow_o, bus.count_o, DEPTH);
    end
    for (int i = 0; i < DEPTH; i++) begin
      drive(0, 0, 1, 0, '0, '0, '0);
      vectors++;
      if (obsv() !== expv()) begin
        miscompares++;
        $display("FAIL drain_%0d: got %h want %h", i, obsv(), expv());
      end
    end
  endtask

  task automatic test_back_to_back();
    clean();
    for (int i = 0; i < 4; i++) drive(0, 1, 0, 0, $urandom, $urandom, $urandom);
    for (int i = 0; i < 20; i++) begin
      drive(0, 1, 1, 0, $urandom, $urandom, $urandom);
      vectors++;
      if (obsv() !== expv() || bus.count_o !== 4'd4) begin
        miscompares++;
        $display("FAIL steady_%0d: got %h want %h", i, obsv(), expv());
      end
    end
  endtask

  task automatic test_simultaneous();
    clean();
    for (int i = 0; i < DEPTH; i++) drive(0, 1, 0, 0, $urandom, $urandom, $urandom);
    drive(0, 1, 1, 0, $urandom, $urandom, $urandom);
    vectors++;
    if (obsv() !== expv() || bus.count_o !== 4'd7 || bus.overflow_o !== 1'b1) begin
      miscompares++;
      $display("FAIL pushpop_full: got %h want %h", obsv(), expv());
    end
    clean();
    drive(0, 1, 1, 0, 32'hCAFE_0001, 32'h55, 32'hAA);
    vectors++;
    if (obsv() !== expv() || bus.count_o !== 4'd1 || bus.underflow_o !== 1'b1
        || bus.instr_o !== 32'hCAFE_0001) begin
      miscompares++;
      $display("FAIL pushpop_empty: got %h want %h", obsv(), expv());
    end
  endtask

  task automatic test_flush_errclr();
    clean();
    for (int i = 0; i < DEPTH; i++) drive(0, 1, 0, 0, $urandom, $urandom, $urandom);
    drive(0, 1, 0, 0, $urandom, $urandom, $urandom);
    for (int i = 0; i < 3; i++) drive(0, 0, 1, 0, '0, '0, '0);
    drive(1, 1, 0, 0, $urandom, $urandom, $urandom);
    vectors++;
    if (obsv() !== expv() || bus.empty_o !== 1'b1 || bus.overflow_o !== 1'b1) begin
      miscompares++;
      $display("FAIL flush_push: got %h want %h", obsv(), expv());
    end
    drive(0, 0, 1, 1, '0, '0, '0);
    vectors++;
    if (obsv() !== expv() || bus.underflow_o !== 1'b1 || bus.overflow_o !== 1'b0) begin
      miscompares++;
      $display("FAIL errclr_setwins: got %h want %h", obsv(), expv());
    end
  endtask

  task automatic test_random();
    bit fl, pu, po, cl;
    clean();
    for (int i = 0; i < 400; i++) begin
      if ((i / 40) % 2 == 0) begin
        pu = ($urandom_range(0, 3) != 0); po = ($urandom_range(0, 3) == 0);
      end else begin
        pu = ($urandom_range(0, 3) == 0); po = ($urandom_range(0, 3) != 0);
      end
      fl = ($urandom_range(0, 47) == 0);
      cl = ($urandom_range(0, 15) == 0);
      drive(fl, pu, po, cl, $urandom, $urandom, $urandom);
      vectors++;
      if (obsv() !== expv()) begin
        miscompares++;
        $display("FAIL random_%0d: got %h want %h", i, obsv(), expv());
      end
    end
  endtask

  task automatic test_async_reset();
    clean();
    for (int i = 0; i < 5; i++) drive(0, 1, 0, 0, $urandom, $urandom, $urandom);
    drive(0, 0, 1, 1, '0, '0, '0);
    drive(0, 0, 1, 0, '0, '0, '0);
    drive(0, 1, 1, 0, $urandom, $urandom, $urandom);
    #2 rst = 1'b1;
    mq.delete(); m_ovf = 0; m_udf = 0;
    #1;
    vectors++;
    if (obsv() !== expv()) begin
      miscompares++;
      $display("FAIL async_reset: got %h want %h", obsv(), expv());
    end
    #1 rst = 1'b0;
    drive(0, 1, 0, 0, 32'h0000_0A57, 32'h7, 32'h9);
    vectors++;
    if (obsv() !== expv()) begin
      miscompares++;
      $display("FAIL post_reset_push: got %h want %h", obsv(), expv());
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill_overflow();
    test_back_to_back();
    test_simultaneous();
    test_flush_errclr();
    test_random();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
